// File: rtl/mem_pkg.sv
// Shared types and constants for the word-organised memory responder.
package mem_pkg;

   localparam int WORD_W   = 32;
   localparam int OFFSET_W = 2;
   localparam int INDEX_W  = WORD_W - OFFSET_W;

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } e_mem_state;

   // Word index range check done at full width so no index can wrap into range.
   function automatic logic idx_in_range(input logic [INDEX_W-1:0] idx, input int depth);
      return {{OFFSET_W{1'b0}}, idx} < WORD_W'(depth);
   endfunction

endpackage

// File: rtl/mem_array.sv
// MEM_DEPTH x 32 storage: an access write port, a backdoor load port and one
// asynchronous read port. Out-of-range indices are ignored on every port.
module mem_array
   import mem_pkg::*;
#(
   parameter int MEM_DEPTH = 1024
) (
   input  logic               clk,
   input  logic               acc_we,
   input  logic [INDEX_W-1:0] acc_idx,
   input  logic [WORD_W-1:0]  acc_data,
   input  logic               ld_we,
   input  logic [INDEX_W-1:0] ld_idx,
   input  logic [WORD_W-1:0]  ld_data,
   input  logic [INDEX_W-1:0] rd_idx,
   output logic [WORD_W-1:0]  rd_data
);

   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   logic [WORD_W-1:0] mem_q [MEM_DEPTH];
   logic              acc_ok;
   logic              ld_ok;
   logic              rd_ok;
   logic              ld_shadowed;

   always_comb begin
      acc_ok      = acc_we && idx_in_range(acc_idx, MEM_DEPTH);
      ld_ok       = ld_we && idx_in_range(ld_idx, MEM_DEPTH);
      rd_ok       = idx_in_range(rd_idx, MEM_DEPTH);
      // A completing access write beats a backdoor load to the same word.
      ld_shadowed = acc_ok && (acc_idx == ld_idx);
   end

   always_ff @(posedge clk) begin
      if (ld_ok && !ld_shadowed) begin
         mem_q[ld_idx[AW-1:0]] <= ld_data;
      end
      if (acc_ok) begin
         mem_q[acc_idx[AW-1:0]] <= acc_data;
      end
   end

   assign rd_data = rd_ok ? mem_q[rd_idx[AW-1:0]] : '0;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request at a time, holds busy
// while it is in flight, then pulses ack (with read data for reads).
module mem_responder
   import mem_pkg::*;
#(
   parameter int MEM_DEPTH   = 1024,
   parameter int MEM_LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wr_data,
   input  logic        mem_rd_req,
   input  logic        mem_wr_req,
   output logic [31:0] mem_rd_data,
   output logic        mem_ack,
   output logic        mem_busy,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic        proto_err,
   output logic        oob_err
);

   localparam int              CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   e_mem_state         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [INDEX_W-1:0] idx_q, idx_d;
   logic               is_wr_q, is_wr_d;
   logic [WORD_W-1:0]  wdata_q, wdata_d;
   logic [WORD_W-1:0]  rd_data_q, rd_data_d;
   logic               ack_q, ack_d;
   logic               proto_q, proto_d;
   logic               oob_q, oob_d;

   logic               any_req;
   logic               complete;
   logic [WORD_W-1:0]  arr_rd_data;
   logic               unused_addr_bits;

   assign unused_addr_bits = ^{mem_addr[OFFSET_W-1:0], load_addr[OFFSET_W-1:0]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      is_wr_d   = is_wr_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;
      ack_d     = 1'b0;
      proto_d   = proto_q;
      oob_d     = oob_q;
      complete  = 1'b0;
      any_req   = mem_rd_req | mem_wr_req;

      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d = S_WAIT;
               cnt_d   = CNT_LOAD;
               idx_d   = mem_addr[WORD_W-1:OFFSET_W];
               // With both requests high the write wins and the read is dropped.
               is_wr_d = mem_wr_req;
               wdata_d = mem_wr_data;
               if (mem_rd_req && mem_wr_req) begin
                  proto_d = 1'b1;
               end
               if (!idx_in_range(mem_addr[WORD_W-1:OFFSET_W], MEM_DEPTH)) begin
                  oob_d = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (any_req) begin
               proto_d = 1'b1;
            end
            if (cnt_q == '0) begin
               complete = 1'b1;
               state_d  = S_IDLE;
               ack_d    = 1'b1;
               if (!is_wr_q) begin
                  rd_data_d = arr_rd_data;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         is_wr_q   <= 1'b0;
         wdata_q   <= '0;
         rd_data_q <= '0;
         ack_q     <= 1'b0;
         proto_q   <= 1'b0;
         oob_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         is_wr_q   <= is_wr_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
         ack_q     <= ack_d;
         proto_q   <= proto_d;
         oob_q     <= oob_d;
      end
   end

   mem_array #(
      .MEM_DEPTH(MEM_DEPTH)
   ) u_array (
      .clk     (clk),
      .acc_we  (complete && is_wr_q && !rst),
      .acc_idx (idx_q),
      .acc_data(wdata_q),
      .ld_we   (load_en),
      .ld_idx  (load_addr[WORD_W-1:OFFSET_W]),
      .ld_data (load_data),
      .rd_idx  (idx_q),
      .rd_data (arr_rd_data)
   );

   // Busy drops in the last wait cycle so the ack cycle reads as idle.
   assign mem_busy    = (state_q == S_WAIT) && (cnt_q != '0);
   assign mem_ack     = ack_q;
   assign mem_rd_data = rd_data_q;
   assign proto_err   = proto_q;
   assign oob_err     = oob_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance at latency 4 and one at latency 1,
// each checked cycle by cycle against a word-array reference model.
module tb_mem_responder;

   localparam int DEPTH = 1024;
   localparam int LAT_A = 4;
   localparam int LAT_B = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr    [2];
   logic [31:0] wdata   [2];
   logic [31:0] ld_addr [2];
   logic [31:0] ld_data [2];
   logic [31:0] rd_data [2];
   logic        rd_req  [2];
   logic        wr_req  [2];
   logic        ld_en   [2];
   logic        ack     [2];
   logic        busy    [2];
   logic        perr    [2];
   logic        oerr    [2];

   always #5 clk = ~clk;

   mem_responder #(.MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT_A)) dut_a (
      .clk(clk), .rst(rst), .mem_addr(addr[0]), .mem_wr_data(wdata[0]),
      .mem_rd_req(rd_req[0]), .mem_wr_req(wr_req[0]), .mem_rd_data(rd_data[0]),
      .mem_ack(ack[0]), .mem_busy(busy[0]), .load_en(ld_en[0]),
      .load_addr(ld_addr[0]), .load_data(ld_data[0]),
      .proto_err(perr[0]), .oob_err(oerr[0])
   );

   mem_responder #(.MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT_B)) dut_b (
      .clk(clk), .rst(rst), .mem_addr(addr[1]), .mem_wr_data(wdata[1]),
      .mem_rd_req(rd_req[1]), .mem_wr_req(wr_req[1]), .mem_rd_data(rd_data[1]),
      .mem_ack(ack[1]), .mem_busy(busy[1]), .load_en(ld_en[1]),
      .load_addr(ld_addr[1]), .load_data(ld_data[1]),
      .proto_err(perr[1]), .oob_err(oerr[1])
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] ref_mem  [2][DEPTH];
   bit          known    [2][DEPTH];
   logic [31:0] exp_rd   [2];
   logic        exp_perr [2];
   logic        exp_oerr [2];

   function automatic int lat(input int s);
      return (s == 0) ? LAT_A : LAT_B;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int s, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
      rd_req[s] = rd;
      wr_req[s] = wr;
      addr[s]   = a;
      wdata[s]  = d;
   endtask

   task automatic set_load(input int s, input logic en, input logic [31:0] a, input logic [31:0] d);
      ld_en[s]   = en;
      ld_addr[s] = a;
      ld_data[s] = d;
   endtask

   // Starts and ends at a negedge; out-of-range loads leave the model untouched.
   task automatic preload(input int s, input logic [31:0] a, input logic [31:0] d);
      int idx;
      idx = int'(a >> 2);
      set_load(s, 1'b1, a, d);
      @(posedge clk);
      #1 set_load(s, 1'b0, '0, '0);
      if ((a >> 2) < DEPTH) begin
         ref_mem[s][idx] = d;
         known[s][idx]   = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic check_idle_outputs(input int s, input string tag);
      check($sformatf("%s_rd_data%0d", tag, s), rd_data[s], 32'h0);
      check($sformatf("%s_ack%0d", tag, s), 32'(ack[s]), 32'h0);
      check($sformatf("%s_busy%0d", tag, s), 32'(busy[s]), 32'h0);
      check($sformatf("%s_perr%0d", tag, s), 32'(perr[s]), 32'h0);
      check($sformatf("%s_oerr%0d", tag, s), 32'(oerr[s]), 32'h0);
   endtask

   // One request presented at the current negedge. Every following cycle up to
   // the ack cycle is checked; the task returns at the ack-cycle negedge so the
   // next call presents its request in the ack cycle.
   // intrude_j >= 0 pulses a stray write during wait cycle intrude_j;
   // collide drives a backdoor load to the same word at the completion edge.
   task automatic access(input int s, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input int intrude_j, input bit collide, input string tag);
      int          l;
      int          idx;
      bit          in_rng;
      bit          is_wr;
      logic [31:0] new_rd;
      l      = lat(s);
      idx    = int'(a >> 2);
      in_rng = (a >> 2) < DEPTH;
      is_wr  = wr;
      new_rd = exp_rd[s];
      if (!is_wr) new_rd = in_rng ? ref_mem[s][idx] : 32'h0;
      set_req(s, rd, wr, a, d);
      @(posedge clk);
      #1 set_req(s, 1'b0, 1'b0, '0, '0);
      if (rd && wr) exp_perr[s] = 1'b1;
      if (!in_rng)  exp_oerr[s] = 1'b1;
      for (int j = 0; j <= l; j++) begin
         @(negedge clk);
         if (j == l) exp_rd[s] = new_rd;
         check($sformatf("%s_busy%0d_c%0d", tag, s, j), 32'(busy[s]), 32'(j <= l - 2));
         check($sformatf("%s_ack%0d_c%0d", tag, s, j), 32'(ack[s]), 32'(j == l));
         check($sformatf("%s_rdata%0d_c%0d", tag, s, j), rd_data[s], exp_rd[s]);
         if (j == l) begin
            check($sformatf("%s_perr%0d", tag, s), 32'(perr[s]), 32'(exp_perr[s]));
            check($sformatf("%s_oerr%0d", tag, s), 32'(oerr[s]), 32'(exp_oerr[s]));
            set_load(s, 1'b0, '0, '0);
         end
         if (j == intrude_j + 1) set_req(s, 1'b0, 1'b0, '0, '0);
         if (j == intrude_j && j < l) begin
            set_req(s, 1'b0, 1'b1, a ^ 32'h4, 32'h5555_aaaa);
            exp_perr[s] = 1'b1;
         end
         if (collide && is_wr && j == l - 1) set_load(s, 1'b1, a, ~d);
      end
      if (is_wr && in_rng) begin
         ref_mem[s][idx] = d;
         known[s][idx]   = 1'b1;
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         set_req(s, 1'b0, 1'b0, '0, '0);
         set_load(s, 1'b0, '0, '0);
         exp_rd[s]   = '0;
         exp_perr[s] = 1'b0;
         exp_oerr[s] = 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            known[s][i]   = 1'b0;
            ref_mem[s][i] = '0;
         end
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs(0, "reset");
      check_idle_outputs(1, "reset");

      // Preloaded fetch, then write followed by a read presented in the ack cycle.
      preload(0, 32'h0, 32'h0010_0093);
      access(0, 1'b1, 1'b0, 32'h0, '0, -1, 1'b0, "fetch");
      access(0, 1'b0, 1'b1, 32'h40, 32'hdead_beef, -1, 1'b0, "wr40");
      access(0, 1'b1, 1'b0, 32'h40, '0, -1, 1'b0, "rd40");

      // Latency 1: back-to-back reads.
      preload(1, 32'h0, 32'd1);
      preload(1, 32'h4, 32'd2);
      preload(1, 32'h8, 32'd3);
      access(1, 1'b1, 1'b0, 32'h0, '0, -1, 1'b0, "b2b0");
      access(1, 1'b1, 1'b0, 32'h4, '0, -1, 1'b0, "b2b1");
      access(1, 1'b1, 1'b0, 32'h8, '0, -1, 1'b0, "b2b2");

      // Out of range: read returns 0, write must not alias onto word 0.
      access(0, 1'b1, 1'b0, 32'(4 * DEPTH), '0, -1, 1'b0, "oob_rd");
      access(0, 1'b0, 1'b1, 32'(4 * DEPTH), 32'h7777_7777, -1, 1'b0, "oob_wr");
      access(0, 1'b1, 1'b0, 32'h0, '0, -1, 1'b0, "alias0");

      // Protocol errors: stray write while busy, then rd+wr together.
      preload(0, 32'h20, 32'ha5a5_0001);
      access(0, 1'b1, 1'b0, 32'h20, '0, 1, 1'b0, "intrude");
      access(0, 1'b1, 1'b0, 32'h24, '0, -1, 1'b0, "intr_chk");
      access(0, 1'b1, 1'b1, 32'h28, 32'h0bad_f00d, -1, 1'b0, "rdwr");
      access(0, 1'b1, 1'b0, 32'h28, '0, -1, 1'b0, "rdwr_chk");

      // Backdoor load colliding with a completing write.
      for (int s = 0; s < 2; s++) begin
         access(s, 1'b0, 1'b1, 32'h30, 32'h1111_2222, -1, 1'b1, "collide");
         access(s, 1'b1, 1'b0, 32'h30, '0, -1, 1'b0, "coll_chk");
      end

      // Randomized traffic over a small window plus occasional out-of-range.
      for (int s = 0; s < 2; s++) begin
         for (int n = 0; n < 30; n++) begin
            int          idx;
            logic [31:0] a;
            logic [31:0] d;
            bit          rd;
            bit          wr;
            idx = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) idx = DEPTH + idx;
            a  = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            d  = $urandom;
            rd = $urandom_range(0, 1) == 1;
            wr = !rd || ($urandom_range(0, 9) == 0);
            if (idx < DEPTH && !known[s][idx]) begin
               rd = 1'b0;
               wr = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) preload(s, a ^ 32'h4, $urandom);
            access(s, rd, wr, a, d, -1, $urandom_range(0, 3) == 0, "rand");
         end
      end

      // Reset two cycles into a write: aborted, no ack, word unchanged.
      preload(0, 32'h10, 32'h1234_5678);
      set_req(0, 1'b0, 1'b1, 32'h10, 32'hcafe_cafe);
      @(posedge clk);
      #1 set_req(0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         exp_rd[s]   = '0;
         exp_perr[s] = 1'b0;
         exp_oerr[s] = 1'b0;
      end
      check_idle_outputs(0, "mid_rst");
      check_idle_outputs(1, "mid_rst");
      for (int j = 0; j < LAT_A + 2; j++) begin
         @(negedge clk);
         check($sformatf("post_rst_ack_c%0d", j), 32'(ack[0]), 32'h0);
         check($sformatf("post_rst_busy_c%0d", j), 32'(busy[0]), 32'h0);
      end
      access(0, 1'b1, 1'b0, 32'h10, '0, -1, 1'b0, "rst_word");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
